// File: rtl/shiftreg_cmd_ctrl_pkg.sv
// Shared encodings for the shift-register command sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package shiftreg_pkg;

  // Universal shift register select encodings
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHL  = 2'b01;
  localparam logic [1:0] SEL_SHR  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  // Command opcodes
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/shiftreg_cmd_ctrl_if.sv
// Command channel into the shift-register sequencer.
// Latency: n/a (wires only).
// Backpressure: valid/ready; a command is taken when both are high at a clk edge.
interface shiftreg_cmd_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_sin;
  logic             cmd_rot;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count, cmd_sin, cmd_rot,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count, cmd_sin, cmd_rot,
    output cmd_ready
  );
endinterface

// File: rtl/shiftreg_cmd_ctrl_counter.sv
// Down counter for the remaining shift cycles of one command.
// Latency: load/decrement visible one cycle later; last is combinational from the count.
// Backpressure: none; load has priority over decrement.
module shift_down_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload on accept, otherwise count down while shifting
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // One shift cycle left: this is the final shift edge
  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shiftreg_cmd_ctrl.sv
// Sequences load/shift commands onto a universal shift register; optional SHIFT_ROTATE_EN macro adds rotate.
// Latency from accept edge: NOP done +1, LOAD done +2, SHL/SHR of N done +N+1; result updates after done.
// Backpressure: cmd_ready only in IDLE (and not in reset); next accept is the first IDLE cycle after DONE.
module shiftreg_cmd_ctrl
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  shiftreg_cmd_ctrl_if.slave   cmd,
  input  logic [WIDTH-1:0]     sr_pdout,
  output logic [1:0]           sel,
  output logic [WIDTH-1:0]     p_din,
  output logic                 s_left_din,
  output logic                 s_right_din,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result
);

  state_e           state_q, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic             sin_q;
  logic [WIDTH-1:0] result_q;
  logic             accept;
  logic             cnt_last;

  assign cmd.cmd_ready = (state_q == ST_IDLE) && !rst;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  shift_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i (cmd.cmd_count),
    .dec_i      (state_q == ST_SHIFT),
    .last_o     (cnt_last)
  );

  // State register; reset drops any in-flight command without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the command fields at accept so later input changes are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= OP_NOP;
      data_q <= '0;
      sin_q  <= 1'b0;
    end else if (accept) begin
      op_q   <= cmd.cmd_op;
      data_q <= cmd.cmd_data;
      sin_q  <= cmd.cmd_sin;
    end
  end

`ifdef SHIFT_ROTATE_EN
  logic rot_q;

  // Rotate request is latched alongside the rest of the command
  always_ff @(posedge clk) begin
    if (rst) begin
      rot_q <= 1'b0;
    end else if (accept) begin
      rot_q <= cmd.cmd_rot;
    end
  end
`endif

  // Capture the register value in DONE, after the last shift/load edge has passed
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else if (state_q == ST_DONE) begin
      result_q <= sr_pdout;
    end
  end

  // Next-state: zero-count shifts and NOPs go straight to DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_LOAD: state_d = ST_LOAD;
            OP_SHL, OP_SHR:
              state_d = (cmd.cmd_count != '0) ? ST_SHIFT : ST_DONE;
            default: state_d = ST_DONE;
          endcase
        end
      end
      ST_LOAD:  state_d = ST_DONE;
      ST_SHIFT: if (cnt_last) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Moore outputs to the shift register; serial-in is combinational only when rotating
  always_comb begin
    sel         = SEL_HOLD;
    p_din       = '0;
    s_left_din  = 1'b0;
    s_right_din = 1'b0;
    case (state_q)
      ST_LOAD: begin
        sel   = SEL_LOAD;
        p_din = data_q;
      end
      ST_SHIFT: begin
        if (op_q == OP_SHL) begin
          sel        = SEL_SHL;
          s_left_din = sin_q;
`ifdef SHIFT_ROTATE_EN
          if (rot_q) s_left_din = sr_pdout[WIDTH-1];
`endif
        end else begin
          sel         = SEL_SHR;
          s_right_din = sin_q;
`ifdef SHIFT_ROTATE_EN
          if (rot_q) s_right_din = sr_pdout[0];
`endif
        end
      end
      default: ;
    endcase
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_shiftreg_cmd_ctrl.sv
// Directed bench for shiftreg_cmd_ctrl driving a behavioural 4-bit universal shift register.
// Inputs change at negedge or #1 after posedge; outputs are sampled at negedge.
// Each scenario task checks its own expectations inline.
module tb_shiftreg_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sel;
  logic [3:0] p_din;
  logic       s_left_din, s_right_din, busy, done;
  logic [3:0] result;
  logic [3:0] sr_q = 4'b0000;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shiftreg_cmd_ctrl_if #(.WIDTH(4), .CNT_W(4)) cmd_if ();

  shiftreg_cmd_ctrl #(.WIDTH(4), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd_if),
    .sr_pdout    (sr_q),
    .sel         (sel),
    .p_din       (p_din),
    .s_left_din  (s_left_din),
    .s_right_din (s_right_din),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  // Universal shift register: 00 hold, 01 shl (sl enters bit0), 10 shr (sr enters bit3), 11 load
  always_ff @(posedge clk) begin
    case (sel)
      2'b01:   sr_q <= {sr_q[2:0], s_left_din};
      2'b10:   sr_q <= {s_right_din, sr_q[3:1]};
      2'b11:   sr_q <= p_din;
      default: sr_q <= sr_q;
    endcase
  end

  // Present a command from a negedge, let it be accepted at the next posedge,
  // then drop valid and scramble the fields. Returns at posedge+1 (cycle +1 begins).
  task automatic issue(input logic [1:0] op, input logic [3:0] data,
                       input logic [3:0] count, input logic sin, input logic rot);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    cmd_if.cmd_count = count;
    cmd_if.cmd_sin   = sin;
    cmd_if.cmd_rot   = rot;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = ~op;
    cmd_if.cmd_data  = ~data;
    cmd_if.cmd_count = ~count;
    cmd_if.cmd_sin   = ~sin;
    cmd_if.cmd_rot   = ~rot;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (sel !== 2'b00) begin errors++; $display("FAIL rst_sel got %b exp 00", sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    checks++; if (result !== 4'b0000) begin errors++; $display("FAIL rst_result got %b exp 0000", result); end
    checks++; if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", cmd_if.cmd_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", cmd_if.cmd_ready); end
  endtask

  task automatic test_load();
    issue(2'b11, 4'b1101, 4'd0, 1'b0, 1'b0);
    @(negedge clk); // +1
    checks++; if (sel !== 2'b11) begin errors++; $display("FAIL load_sel got %b exp 11", sel); end
    checks++; if (p_din !== 4'b1101) begin errors++; $display("FAIL load_pdin got %b exp 1101", p_din); end
    checks++; if (done !== 1'b0 || busy !== 1'b1 || cmd_if.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL load_busy done=%b busy=%b ready=%b exp 0 1 0", done, busy, cmd_if.cmd_ready); end
    @(negedge clk); // +2
    checks++; if (sel !== 2'b00) begin errors++; $display("FAIL load_sel_once got %b exp 00", sel); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL load_done got %b exp 1", done); end
    @(negedge clk); // +3
    checks++; if (result !== 4'b1101) begin errors++; $display("FAIL load_result got %b exp 1101", result); end
    checks++; if (done !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL load_idle done=%b ready=%b exp 0 1", done, cmd_if.cmd_ready); end
  endtask

  task automatic test_shl();
    issue(2'b01, 4'b0000, 4'd2, 1'b1, 1'b0);
    @(negedge clk); // +1
    checks++; if (sel !== 2'b01 || s_left_din !== 1'b1 || s_right_din !== 1'b0) begin
      errors++; $display("FAIL shl_c1 sel=%b sl=%b sr=%b exp 01 1 0", sel, s_left_din, s_right_din); end
    @(negedge clk); // +2
    checks++; if (sel !== 2'b01 || sr_q !== 4'b1011) begin
      errors++; $display("FAIL shl_c2 sel=%b reg=%b exp 01 1011", sel, sr_q); end
    @(negedge clk); // +3
    checks++; if (sel !== 2'b00 || done !== 1'b1 || sr_q !== 4'b0111) begin
      errors++; $display("FAIL shl_done sel=%b done=%b reg=%b exp 00 1 0111", sel, done, sr_q); end
    @(negedge clk);
    checks++; if (result !== 4'b0111) begin errors++; $display("FAIL shl_result got %b exp 0111", result); end
  endtask

  task automatic test_shr_and_zero();
    issue(2'b10, 4'b0000, 4'd1, 1'b0, 1'b0);
    @(negedge clk); // +1
    checks++; if (sel !== 2'b10 || s_right_din !== 1'b0 || s_left_din !== 1'b0) begin
      errors++; $display("FAIL shr_c1 sel=%b sr=%b sl=%b exp 10 0 0", sel, s_right_din, s_left_din); end
    @(negedge clk); // +2
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL shr_done got %b exp 1", done); end
    @(negedge clk);
    checks++; if (result !== 4'b0011) begin errors++; $display("FAIL shr_result got %b exp 0011", result); end
    issue(2'b01, 4'b0000, 4'd0, 1'b1, 1'b0);
    @(negedge clk); // +1
    checks++; if (sel !== 2'b00 || done !== 1'b1) begin
      errors++; $display("FAIL zero_done sel=%b done=%b exp 00 1", sel, done); end
    @(negedge clk);
    checks++; if (result !== 4'b0011 || cmd_if.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL zero_result result=%b ready=%b exp 0011 1", result, cmd_if.cmd_ready); end
    issue(2'b00, 4'b1111, 4'd5, 1'b1, 1'b0);
    @(negedge clk); // +1
    checks++; if (sel !== 2'b00 || done !== 1'b1 || sr_q !== 4'b0011) begin
      errors++; $display("FAIL nop_done sel=%b done=%b reg=%b exp 00 1 0011", sel, done, sr_q); end
    @(negedge clk);
  endtask

  task automatic test_reset_midshift();
    logic seen_done;
    seen_done = 1'b0;
    issue(2'b01, 4'b0000, 4'd8, 1'b1, 1'b0);
    @(negedge clk); // +1
    @(negedge clk); // +2
    @(negedge clk); // +3: third shift cycle
    checks++; if (sel !== 2'b01) begin errors++; $display("FAIL mid_sel3 got %b exp 01", sel); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (sel !== 2'b00 || busy !== 1'b0 || cmd_if.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rst sel=%b busy=%b ready=%b exp 00 0 0", sel, busy, cmd_if.cmd_ready); end
    if (done) seen_done = 1'b1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL mid_nodone got %b exp 0", seen_done); end
    checks++; if (cmd_if.cmd_ready !== 1'b1 || result !== 4'b0000) begin
      errors++; $display("FAIL mid_after ready=%b result=%b exp 1 0000", cmd_if.cmd_ready, result); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 2'b11;
    cmd_if.cmd_data  = 4'b0110;
    cmd_if.cmd_count = 4'd0;
    cmd_if.cmd_sin   = 1'b0;
    cmd_if.cmd_rot   = 1'b0;
    @(negedge clk); // +1 after first accept
    checks++; if (sel !== 2'b11 || cmd_if.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_c1 sel=%b ready=%b exp 11 0", sel, cmd_if.cmd_ready); end
    @(negedge clk); // +2
    checks++; if (done !== 1'b1 || cmd_if.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_c2 done=%b ready=%b exp 1 0", done, cmd_if.cmd_ready); end
    @(negedge clk); // +3: IDLE, second accept at next edge
    checks++; if (sel !== 2'b00 || cmd_if.cmd_ready !== 1'b1 || result !== 4'b0110) begin
      errors++; $display("FAIL b2b_c3 sel=%b ready=%b result=%b exp 00 1 0110", sel, cmd_if.cmd_ready, result); end
    @(negedge clk); // +4
    cmd_if.cmd_valid = 1'b0;
    checks++; if (sel !== 2'b11) begin errors++; $display("FAIL b2b_c4 sel got %b exp 11", sel); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rotate();
    logic [3:0] exp1, exp4;
`ifdef SHIFT_ROTATE_EN
    exp1 = 4'b1011;
    exp4 = 4'b1101;
`else
    exp1 = 4'b1010;
    exp4 = 4'b0000;
`endif
    issue(2'b11, 4'b1101, 4'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    issue(2'b01, 4'b0000, 4'd1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (result !== exp1) begin errors++; $display("FAIL rot1_result got %b exp %b", result, exp1); end
    issue(2'b11, 4'b1101, 4'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    issue(2'b01, 4'b0000, 4'd4, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    checks++; if (result !== exp4) begin errors++; $display("FAIL rot4_result got %b exp %b", result, exp4); end
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_data  = 4'b0000;
    cmd_if.cmd_count = 4'd0;
    cmd_if.cmd_sin   = 1'b0;
    cmd_if.cmd_rot   = 1'b0;
    test_reset();
    test_load();
    test_shl();
    test_shr_and_zero();
    test_reset_midshift();
    test_back_to_back();
    test_rotate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
